// File: rtl/k051962_tile_serializer.sv
// Tile serializer: one 32-bit plane word plus attribute per tile in, 12-bit {attr, pix} codes out; optional OPAQUE flag under K051962_OPAQUE_FLAG_EN.
// Latency: tile pixel 0 reaches DOUT on the (1 + FSCR)th PXE edge after the loading edge.
// No backpressure: fully paced by PXE, and DOUT holds its value between enables.
module k051962_tile_serializer #(
    parameter int FLIPX_BIT    = 0,
    parameter int FLIPX_ENABLE = 1
) (
    input  logic        M24,
    input  logic        RES,
    input  logic        PXE,
    input  logic        HLOAD,
    input  logic [31:0] VD,
    input  logic [7:0]  COL,
    input  logic [2:0]  FSCR,
    input  logic        BEN,
    output logic [11:0] DOUT
`ifdef K051962_OPAQUE_FLAG_EN
    ,
    output logic        OPAQUE
`endif
);

    logic [31:0] sr;
    logic [7:0]  ar;
    logic        fl;
    logic [11:0] dl [0:6];

    logic [3:0]  pix;
    logic [11:0] pc;
    logic [11:0] sel;
    logic [31:0] sr_shift;
    logic        flip_load;

    // The tap sits on bit 7 of each plane normally and on bit 0 when flipped.
    always_comb begin
        if (fl) begin
            pix = {sr[24], sr[16], sr[8], sr[0]};
        end else begin
            pix = {sr[31], sr[23], sr[15], sr[7]};
        end
    end

    assign pc = {ar, pix};

    // Each plane moves toward its tap; the masks stop bits crossing plane boundaries.
    always_comb begin
        if (fl) begin
            sr_shift = (sr >> 1) & 32'h7F7F_7F7F;
        end else begin
            sr_shift = (sr << 1) & 32'hFEFE_FEFE;
        end
    end

    assign flip_load = (FLIPX_ENABLE != 0) && COL[FLIPX_BIT];

    always_comb begin
        case (FSCR)
            3'd1:    sel = dl[0];
            3'd2:    sel = dl[1];
            3'd3:    sel = dl[2];
            3'd4:    sel = dl[3];
            3'd5:    sel = dl[4];
            3'd6:    sel = dl[5];
            3'd7:    sel = dl[6];
            default: sel = pc;
        endcase
    end

    always_ff @(posedge M24 or negedge RES) begin
        if (!RES) begin
            sr <= '0;
            ar <= '0;
            fl <= 1'b0;
        end else if (PXE) begin
            if (HLOAD) begin
                sr <= VD;
                ar <= COL;
                fl <= flip_load;
            end else begin
                sr <= sr_shift;
            end
        end
    end

    // The delay line keeps running while blanked so the first unblanked pixel is already correct.
    always_ff @(posedge M24 or negedge RES) begin
        if (!RES) begin
            for (int k = 0; k < 7; k++) begin
                dl[k] <= '0;
            end
        end else if (PXE) begin
            dl[0] <= pc;
            for (int k = 1; k < 7; k++) begin
                dl[k] <= dl[k-1];
            end
        end
    end

    always_ff @(posedge M24 or negedge RES) begin
        if (!RES) begin
            DOUT <= '0;
        end else if (PXE) begin
            DOUT <= BEN ? sel : 12'h000;
        end
    end

`ifdef K051962_OPAQUE_FLAG_EN
    always_ff @(posedge M24 or negedge RES) begin
        if (!RES) begin
            OPAQUE <= 1'b0;
        end else if (PXE) begin
            OPAQUE <= BEN && (sel[3:0] != 4'h0);
        end
    end
`endif

endmodule
